// File: rtl/pipe_stage_reg_if.sv
// Valid/ready link between two pipeline stages of the MIPS core.
// The producer side uses the master modport, the consumer side the slave modport.
interface pipe_stage_reg_if #(
    parameter int CTRL_W = 6,
    parameter int AUX_W  = 18,
    parameter int INST_W = 32
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [AUX_W-1:0]  aux;
    logic [INST_W-1:0] inst;

    modport master (output valid, output ctrl, output aux, output inst, input ready);
    modport slave  (input valid, input ctrl, input aux, input inst, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Holds control, auxiliary and instruction fields under a valid/ready
// handshake, with synchronous flush and a NOP bubble when empty.
// Build option: define PIPE_SKID_EN to add a skid entry, which makes
// in_ready a registered signal (two entries held). Without it the block
// holds one entry and in_ready is combinational from out_ready.
module pipe_stage_reg #(
    parameter int                CTRL_W   = 6,
    parameter int                AUX_W    = 18,
    parameter int                INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0020)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    pipe_stage_reg_if.slave         up,
    pipe_stage_reg_if.master        dn,
    output logic [1:0]              count
);

    // Main entry: always the head, drives the downstream outputs.
    logic              m_vld_q, m_vld_d;
    logic [CTRL_W-1:0] m_ctrl_q;
    logic [AUX_W-1:0]  m_aux_q;
    logic [INST_W-1:0] m_inst_q;
    logic              m_load_in;
    logic [1:0]        count_q, count_d;

    logic accept;
    logic rel;

    // flush drops the same-cycle input; in_ready already carries !rst.
    assign accept = up.valid && up.ready && !flush;
    assign rel    = m_vld_q && dn.ready;

`ifdef PIPE_SKID_EN
    // Skid entry: catches the one entry that arrives after out_ready drops.
    logic              s_vld_q, s_vld_d;
    logic [CTRL_W-1:0] s_ctrl_q;
    logic [AUX_W-1:0]  s_aux_q;
    logic [INST_W-1:0] s_inst_q;
    logic              m_load_s;
    logic              s_load;

    // Ready depends only on skid occupancy, so no combinational path from out_ready.
    assign up.ready = !s_vld_q && !rst;

    // Next-state occupancy and load selects for the two-entry configuration.
    always_comb begin
        m_vld_d   = m_vld_q;
        s_vld_d   = s_vld_q;
        m_load_in = 1'b0;
        m_load_s  = 1'b0;
        s_load    = 1'b0;
        if (rst || flush) begin
            m_vld_d = 1'b0;
            s_vld_d = 1'b0;
        end else if (!m_vld_q) begin
            if (accept) begin
                m_vld_d   = 1'b1;
                m_load_in = 1'b1;
            end
        end else if (rel) begin
            if (s_vld_q) begin
                // in_ready is low here, so nothing new arrives this cycle.
                m_load_s = 1'b1;
                s_vld_d  = 1'b0;
            end else if (accept) begin
                m_load_in = 1'b1;
            end else begin
                m_vld_d = 1'b0;
            end
        end else if (accept) begin
            s_vld_d = 1'b1;
            s_load  = 1'b1;
        end
        count_d = {1'b0, m_vld_d} + {1'b0, s_vld_d};
    end

    // Occupancy and count registers; only control state sees reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_vld_q <= 1'b0;
            s_vld_q <= 1'b0;
            count_q <= 2'd0;
        end else begin
            m_vld_q <= m_vld_d;
            s_vld_q <= s_vld_d;
            count_q <= count_d;
        end
    end

    // Payload registers: main loads from input or skid, skid loads from input.
    always_ff @(posedge clk) begin
        if (m_load_in) begin
            m_ctrl_q <= up.ctrl;
            m_aux_q  <= up.aux;
            m_inst_q <= up.inst;
        end else if (m_load_s) begin
            m_ctrl_q <= s_ctrl_q;
            m_aux_q  <= s_aux_q;
            m_inst_q <= s_inst_q;
        end
        if (s_load) begin
            s_ctrl_q <= up.ctrl;
            s_aux_q  <= up.aux;
            s_inst_q <= up.inst;
        end
    end
`else
    // Single entry: a release frees the slot in the same cycle, so ready follows out_ready.
    assign up.ready = !rst && (!m_vld_q || dn.ready);

    // Next-state occupancy and load select for the single-entry configuration.
    always_comb begin
        m_vld_d   = m_vld_q;
        m_load_in = 1'b0;
        if (rst || flush) begin
            m_vld_d = 1'b0;
        end else if (accept) begin
            m_vld_d   = 1'b1;
            m_load_in = 1'b1;
        end else if (rel) begin
            m_vld_d = 1'b0;
        end
        count_d = {1'b0, m_vld_d};
    end

    // Occupancy and count registers; only control state sees reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_vld_q <= 1'b0;
            count_q <= 2'd0;
        end else begin
            m_vld_q <= m_vld_d;
            count_q <= count_d;
        end
    end

    // Payload register loads whenever a new entry is taken.
    always_ff @(posedge clk) begin
        if (m_load_in) begin
            m_ctrl_q <= up.ctrl;
            m_aux_q  <= up.aux;
            m_inst_q <= up.inst;
        end
    end
`endif

    // Stale payload is masked so an empty stage always shows a clean NOP bubble.
    assign dn.valid = m_vld_q;
    assign dn.ctrl  = m_vld_q ? m_ctrl_q : '0;
    assign dn.aux   = m_vld_q ? m_aux_q  : '0;
    assign dn.inst  = m_vld_q ? m_inst_q : NOP_INST;
    assign count    = count_q;

endmodule
